// File: rtl/video_timing_gen_if.sv
// CPU register-window bus shared by the peripherals: select, direction, address,
// write data and registered read data.
interface video_timing_gen_if;
    logic       cs;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] di;
    logic [7:0] dout;

    modport master (output cs, rw, addr, di, input dout);
    modport slave  (input cs, rw, addr, di, output dout);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, registered sync/blank
// flags, frame counter with coherent high-byte shadow, and a sticky vblank irq.
module video_timing_gen #(
    parameter int H_ACTIVE = 160,
    parameter int H_FRONT  = 8,
    parameter int H_SYNC   = 16,
    parameter int H_BACK   = 16,
    parameter int V_ACTIVE = 120,
    parameter int V_FRONT  = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 4,
    parameter int PIX_DIV  = 4
) (
    input  logic              clk,
    input  logic              reset,
    video_timing_gen_if.slave bus,
    output logic [7:0]        hpos,
    output logic [6:0]        vpos,
    output logic              hsync,
    output logic              vsync,
    output logic              display_on,
    output logic              pix_ce,
    output logic              frame_start,
    output logic              irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [7:0]       H_LAST   = 8'(H_TOTAL - 1);
    localparam logic [6:0]       V_LAST   = 7'(V_TOTAL - 1);
    localparam logic [6:0]       V_IRQ    = 7'(V_ACTIVE - 1);

    // Range bounds are one bit wider than the counters so an interval ending
    // exactly at 256 (or 128) still compares correctly.
    localparam logic [8:0] H_ACT9   = 9'(H_ACTIVE);
    localparam logic [8:0] HS_START = 9'(H_ACTIVE + H_FRONT);
    localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [7:0] V_ACT8   = 8'(V_ACTIVE);
    localparam logic [7:0] VS_START = 8'(V_ACTIVE + V_FRONT);
    localparam logic [7:0] VS_END   = 8'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [3:0] A_FRAME_LO = 4'd0;
    localparam logic [3:0] A_FRAME_HI = 4'd1;
    localparam logic [3:0] A_STATUS   = 4'd2;
    localparam logic [3:0] A_CTRL     = 4'd3;
    localparam logic [3:0] A_HPOS     = 4'd4;
    localparam logic [3:0] A_VPOS     = 4'd5;

    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       hpos_q, hpos_d;
    logic [6:0]       vpos_q, vpos_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             display_on_q, display_on_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             frame_start_q, frame_start_d;
    logic             irq_q, irq_d;
    logic             enable_q, enable_d;
    logic [15:0]      frame_q, frame_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       dout_q, dout_d;

    logic pix_ce_w;
    logic h_wrap, v_wrap;
    logic frame_inc, irq_set;
    logic rd, ctrl_wr, frame_clr, irq_ack;
    logic unused_di;

    assign unused_di = ^bus.di[7:3];

    always_comb begin
        div_d         = div_q;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        enable_d      = enable_q;
        frame_d       = frame_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;

        pix_ce_w  = enable_q && (div_q == DIV_LAST);
        h_wrap    = (hpos_q == H_LAST);
        v_wrap    = (vpos_q == V_LAST);
        frame_inc = pix_ce_w && h_wrap && v_wrap;
        irq_set   = pix_ce_w && h_wrap && (vpos_q == V_IRQ);

        rd        = bus.cs && !bus.rw;
        ctrl_wr   = bus.cs && bus.rw && (bus.addr == A_CTRL);
        frame_clr = ctrl_wr && bus.di[1];
        irq_ack   = ctrl_wr && bus.di[2];

        if (enable_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        if (pix_ce_w) begin
            if (h_wrap) begin
                hpos_d = 8'd0;
                vpos_d = v_wrap ? 7'd0 : vpos_q + 7'd1;
            end else begin
                hpos_d = hpos_q + 8'd1;
            end
        end

        // Flags are derived from the next counter values so they line up with
        // hpos/vpos in the same cycle.
        hsync_d      = ({1'b0, hpos_d} >= HS_START) && ({1'b0, hpos_d} < HS_END);
        vsync_d      = ({1'b0, vpos_d} >= VS_START) && ({1'b0, vpos_d} < VS_END);
        hblank_d     = !({1'b0, hpos_d} < H_ACT9);
        vblank_d     = !({1'b0, vpos_d} < V_ACT8);
        display_on_d = !hblank_d && !vblank_d;

        frame_start_d = frame_inc;
        irq_d         = irq_set || (irq_q && !irq_ack);

        if (ctrl_wr) begin
            enable_d = bus.di[0];
        end

        if (frame_clr) begin
            frame_d = 16'd0;
        end else if (frame_inc) begin
            frame_d = frame_q + 16'd1;
        end

        // Reading the low byte freezes the high byte so a two-read sequence
        // sees one coherent 16-bit value.
        if (frame_clr) begin
            shadow_d = 8'd0;
        end else if (rd && (bus.addr == A_FRAME_LO)) begin
            shadow_d = frame_q[15:8];
        end

        if (rd) begin
            case (bus.addr)
                A_FRAME_LO: dout_d = frame_q[7:0];
                A_FRAME_HI: dout_d = shadow_q;
                A_STATUS:   dout_d = {4'b0, irq_q, vsync_q, vblank_q, hblank_q};
                A_CTRL:     dout_d = {7'b0, enable_q};
                A_HPOS:     dout_d = hpos_q;
                A_VPOS:     dout_d = {1'b0, vpos_q};
                default:    dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            hpos_q        <= 8'd0;
            vpos_q        <= 7'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            display_on_q  <= 1'b1;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
            irq_q         <= 1'b0;
            enable_q      <= 1'b1;
            frame_q       <= 16'd0;
            shadow_q      <= 8'd0;
            dout_q        <= 8'h00;
        end else begin
            div_q         <= div_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
            irq_q         <= irq_d;
            enable_q      <= enable_d;
            frame_q       <= frame_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign pix_ce      = pix_ce_w;
    assign frame_start = frame_start_q;
    assign irq         = irq_q;
    assign bus.dout    = dout_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default geometry at PIX_DIV=4 (a) and 1 (c), and a
// tiny 7x5 raster (b) for irq and coherent frame-counter reads.
module tb_video_timing_gen;

    localparam int HA = 160, HF = 8, HS = 16, HT = 200;
    localparam int VA = 120, VF = 2, VS = 2, VT = 128;
    localparam longint FT_A = 4 * HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    video_timing_gen_if bus_a ();
    video_timing_gen_if bus_b ();
    video_timing_gen_if bus_c ();

    logic [7:0] hpos_a, hpos_b, hpos_c;
    logic [6:0] vpos_a, vpos_b, vpos_c;
    logic hsync_a, hsync_b, hsync_c, vsync_a, vsync_b, vsync_c;
    logic disp_a, disp_b, disp_c, pce_a, pce_b, pce_c;
    logic fs_a, fs_b, fs_c, irq_a, irq_b, irq_c;

    video_timing_gen #(.PIX_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a), .hpos(hpos_a), .vpos(vpos_a),
        .hsync(hsync_a), .vsync(vsync_a), .display_on(disp_a), .pix_ce(pce_a),
        .frame_start(fs_a), .irq(irq_a));

    video_timing_gen #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                       .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                       .PIX_DIV(1)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b), .hpos(hpos_b), .vpos(vpos_b),
        .hsync(hsync_b), .vsync(vsync_b), .display_on(disp_b), .pix_ce(pce_b),
        .frame_start(fs_b), .irq(irq_b));

    video_timing_gen #(.PIX_DIV(1)) dut_c (
        .clk(clk), .reset(rst_c), .bus(bus_c), .hpos(hpos_c), .vpos(vpos_c),
        .hsync(hsync_c), .vsync(vsync_c), .display_on(disp_c), .pix_ce(pce_c),
        .frame_start(fs_c), .irq(irq_c));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference raster: counters follow directly from the number of enabled clocks.
    function automatic logic [17:0] m_ras(longint cyc, int pd);
        longint pix;
        int h, v;
        logic hs, vs, disp;
        pix  = cyc / pd;
        h    = int'(pix % HT);
        v    = int'((pix / HT) % VT);
        hs   = (h >= HA + HF) && (h < HA + HF + HS);
        vs   = (v >= VA + VF) && (v < VA + VF + VS);
        disp = (h < HA) && (v < VA);
        return {8'(h), 7'(v), hs, vs, disp};
    endfunction

    function automatic logic [2:0] m_status(longint cyc, int pd);
        longint pix;
        int h, v;
        pix = cyc / pd;
        h   = int'(pix % HT);
        v   = int'((pix / HT) % VT);
        return {(v >= VA + VF) && (v < VA + VF + VS), v >= VA, h >= HA};
    endfunction

    function automatic logic m_pce(longint cyc, int pd, bit en);
        return en && ((cyc % pd) == pd - 1);
    endfunction

    function automatic logic [15:0] m_frame(longint cyc, longint foff);
        return 16'((cyc / FT_A) - foff);
    endfunction

    // Model state for dut_a: enabled-clock count, enable, frame offset, shadow.
    longint   cyc_a, foff_a;
    bit       en_a;
    logic [7:0] shadow_m;
    always @(posedge clk) begin
        if (rst_a) begin
            cyc_a <= 0; en_a <= 1'b1; foff_a <= 0; shadow_m <= 8'h00;
        end else begin
            cyc_a <= cyc_a + (en_a ? 1 : 0);
            if (bus_a.cs && !bus_a.rw && bus_a.addr == 4'd0)
                shadow_m <= 8'(m_frame(cyc_a, foff_a) >> 8);
            if (bus_a.cs && bus_a.rw && bus_a.addr == 4'd3) begin
                en_a <= bus_a.di[0];
                if (bus_a.di[1]) begin
                    foff_a   <= (cyc_a + (en_a ? 1 : 0)) / FT_A;
                    shadow_m <= 8'h00;
                end
            end
        end
    end

    longint cyc_b;
    always @(posedge clk) cyc_b <= rst_b ? 0 : cyc_b + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_bus(input int sel, input logic c, input logic w,
                           input logic [3:0] a, input logic [7:0] d);
        case (sel)
            0: begin bus_a.cs = c; bus_a.rw = w; bus_a.addr = a; bus_a.di = d; end
            1: begin bus_b.cs = c; bus_b.rw = w; bus_b.addr = a; bus_b.di = d; end
            default: begin bus_c.cs = c; bus_c.rw = w; bus_c.addr = a; bus_c.di = d; end
        endcase
    endtask

    task automatic bus_wr(input int sel, input logic [3:0] a, input logic [7:0] d);
        set_bus(sel, 1'b1, 1'b1, a, d);
        tick();
        set_bus(sel, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic bus_rd(input int sel, input logic [3:0] a, output logic [7:0] q);
        set_bus(sel, 1'b1, 1'b0, a, 8'h00);
        tick();
        set_bus(sel, 1'b0, 1'b0, 4'd0, 8'h00);
        case (sel)
            0: q = bus_a.dout;
            1: q = bus_b.dout;
            default: q = bus_c.dout;
        endcase
    endtask

    task automatic do_reset(input int sel);
        case (sel) 0: rst_a = 1'b1; 1: rst_b = 1'b1; default: rst_c = 1'b1; endcase
        tick(); tick();
        case (sel) 0: rst_a = 1'b0; 1: rst_b = 1'b0; default: rst_c = 1'b0; endcase
    endtask

    task automatic test_reset();
        logic [7:0] q;
        rst_a = 1'b0;
        repeat (50) tick();
        bus_rd(0, 4'd4, q);
        rst_a = 1'b1;
        tick(); tick();
        n_tests++;
        if ({hpos_a, vpos_a} !== 15'd0) begin
            n_fail++; $display("FAIL reset_pos: got h=%0d v=%0d expected 0/0", hpos_a, vpos_a);
        end
        n_tests++;
        if ({hsync_a, vsync_a, disp_a, fs_a, irq_a, pce_a} !== 6'b001000) begin
            n_fail++;
            $display("FAIL reset_flags: got hs,vs,disp,fs,irq,pce=%b expected 001000",
                     {hsync_a, vsync_a, disp_a, fs_a, irq_a, pce_a});
        end
        n_tests++;
        if (bus_a.dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: got %h expected 00", bus_a.dout);
        end
        rst_a = 1'b0;
    endtask

    task automatic test_line();
        logic [17:0] obs, ex;
        longint disp_fall = -1, v1 = -1, hs_rise = -1, hs_fall = -1;
        for (int i = 0; i < 1700; i++) begin
            tick();
            obs = {hpos_a, vpos_a, hsync_a, vsync_a, disp_a};
            ex  = m_ras(cyc_a, 4);
            n_tests++;
            if (obs !== ex || pce_a !== m_pce(cyc_a, 4, en_a)) begin
                n_fail++;
                $display("FAIL line_scan cyc=%0d: got %h pce=%b expected %h pce=%b",
                         cyc_a, obs, pce_a, ex, m_pce(cyc_a, 4, en_a));
            end
            if (disp_fall < 0 && disp_a === 1'b0) disp_fall = cyc_a;
            if (v1 < 0 && vpos_a === 7'd1) v1 = cyc_a;
            if (hs_rise < 0 && hsync_a === 1'b1) hs_rise = cyc_a;
            if (hs_rise >= 0 && hs_fall < 0 && hsync_a === 1'b0) hs_fall = cyc_a;
        end
        n_tests++;
        if (disp_fall != 640) begin
            n_fail++; $display("FAIL display_off_cycle: got %0d expected 640", disp_fall);
        end
        n_tests++;
        if (hs_rise != 672 || hs_fall != 736) begin
            n_fail++; $display("FAIL hsync_window: got %0d..%0d expected 672..736", hs_rise, hs_fall);
        end
        n_tests++;
        if (v1 != 800) begin
            n_fail++; $display("FAIL line_length: got %0d expected 800", v1);
        end
    endtask

    task automatic test_enable();
        bit found = 0;
        logic [7:0] prev = hpos_a;
        int bad = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            tick();
            if (hpos_a === 8'd50 && prev === 8'd49) found = 1;
            else prev = hpos_a;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL enable_wait: got timeout expected hpos=50");
        end
        bus_wr(0, 4'd3, 8'h00);
        for (int i = 0; i < 1000; i++) begin
            if (hpos_a !== 8'd50 || pce_a !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL enable_hold: got %0d bad cycles expected 0", bad);
        end
        bus_wr(0, 4'd3, 8'h01);
        for (int i = 0; i < 4 && hpos_a !== 8'd51; i++) tick();
        n_tests++;
        if (hpos_a !== 8'd51) begin
            n_fail++; $display("FAIL enable_resume: got hpos=%0d expected 51", hpos_a);
        end
        n_tests++;
        if ({hpos_a, vpos_a, hsync_a, vsync_a, disp_a} !== m_ras(cyc_a, 4)) begin
            n_fail++; $display("FAIL enable_model: got %h expected %h",
                               {hpos_a, vpos_a, hsync_a, vsync_a, disp_a}, m_ras(cyc_a, 4));
        end
    endtask

    task automatic test_random();
        logic [7:0] q, ex, mask;
        logic [17:0] r;
        logic [3:0] a;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 200)) tick();
            n_tests++;
            if ({hpos_a, vpos_a, hsync_a, vsync_a, disp_a} !== m_ras(cyc_a, 4) ||
                pce_a !== m_pce(cyc_a, 4, en_a)) begin
                n_fail++; $display("FAIL rand_raster it=%0d: got %h expected %h", it,
                                   {hpos_a, vpos_a, hsync_a, vsync_a, disp_a}, m_ras(cyc_a, 4));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus_wr(0, 4'd3, {7'b0, 1'($urandom_range(0, 1))});
            end else begin
                a    = 4'($urandom_range(0, 7));
                r    = m_ras(cyc_a, 4);
                mask = 8'hFF;
                case (a)
                    4'd0: ex = 8'(m_frame(cyc_a, foff_a));
                    4'd1: ex = shadow_m;
                    4'd2: begin ex = {5'b0, m_status(cyc_a, 4)}; mask = 8'hF7; end
                    4'd3: ex = {7'b0, en_a};
                    4'd4: ex = r[17:10];
                    4'd5: ex = {1'b0, r[9:3]};
                    default: ex = 8'h00;
                endcase
                bus_rd(0, a, q);
                n_tests++;
                if ((q & mask) !== ex) begin
                    n_fail++; $display("FAIL rand_read addr=%0d: got %h expected %h", a, q & mask, ex);
                end
            end
        end
        bus_wr(0, 4'd3, 8'h01);
    endtask

    task automatic test_irq();
        logic [7:0] q;
        do_reset(1);
        repeat (13) tick();
        n_tests++;
        if (irq_b !== 1'b0) begin
            n_fail++; $display("FAIL irq_early: got %b expected 0", irq_b);
        end
        tick();
        n_tests++;
        if (irq_b !== 1'b1 || {hpos_b, vpos_b} !== {8'd0, 7'd2}) begin
            n_fail++; $display("FAIL irq_set: got irq=%b h=%0d v=%0d expected 1 0 2", irq_b, hpos_b, vpos_b);
        end
        bus_wr(1, 4'd3, 8'h05);
        n_tests++;
        if (irq_b !== 1'b0) begin
            n_fail++; $display("FAIL irq_ack: got %b expected 0", irq_b);
        end
        bus_rd(1, 4'd3, q);
        n_tests++;
        if (q !== 8'h01) begin
            n_fail++; $display("FAIL irq_ack_ctrl: got %h expected 01", q);
        end
        for (int i = 0; i < 200 && cyc_b != 48; i++) tick();
        bus_wr(1, 4'd3, 8'h05);
        n_tests++;
        if (irq_b !== 1'b1) begin
            n_fail++; $display("FAIL irq_set_wins: got %b expected 1", irq_b);
        end
        bus_wr(1, 4'd3, 8'h05);
        n_tests++;
        if (irq_b !== 1'b0) begin
            n_fail++; $display("FAIL irq_ack2: got %b expected 0", irq_b);
        end
    endtask

    task automatic test_coherent();
        logic [7:0] q;
        logic [7:0] got[7];
        logic [7:0] req[7] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        do_reset(1);
        for (int i = 0; i < 10000 && cyc_b != 255 * 35 + 3; i++) tick();
        bus_rd(1, 4'd0, got[0]);
        bus_rd(1, 4'd1, got[1]);
        for (int i = 0; i < 200 && cyc_b != 256 * 35 + 2; i++) tick();
        bus_rd(1, 4'd1, got[2]);
        bus_rd(1, 4'd0, got[3]);
        bus_rd(1, 4'd1, got[4]);
        for (int i = 0; i < 100 && (cyc_b % 35) != 34; i++) tick();
        bus_wr(1, 4'd3, 8'h03);
        bus_rd(1, 4'd1, got[5]);
        bus_rd(1, 4'd0, got[6]);
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (got[i] !== req[i]) begin
                n_fail++; $display("FAIL coherent_read step=%0d: got %h expected %h", i, got[i], req[i]);
            end
        end
        q = 8'h00;
    endtask

    task automatic test_frame();
        logic [19:0] obs, ex;
        longint first_irq = -1, fs_at = -1, vs_rise = -1, vs_fall = -1;
        logic [7:0] q;
        do_reset(2);
        for (int i = 1; i <= 25601; i++) begin
            tick();
            obs = {hpos_c, vpos_c, hsync_c, vsync_c, disp_c, fs_c, irq_c};
            ex  = {m_ras(i, 1), i == 25600, i >= 24000};
            n_tests++;
            if (obs !== ex) begin
                n_fail++; $display("FAIL frame_scan cyc=%0d: got %h expected %h", i, obs, ex);
            end
            if (first_irq < 0 && irq_c === 1'b1) first_irq = i;
            if (fs_at < 0 && fs_c === 1'b1) fs_at = i;
            if (vs_rise < 0 && vsync_c === 1'b1) vs_rise = i;
            if (vs_rise >= 0 && vs_fall < 0 && vsync_c === 1'b0) vs_fall = i;
        end
        n_tests++;
        if (first_irq != 24000 || fs_at != 25600) begin
            n_fail++; $display("FAIL frame_events: got irq@%0d fs@%0d expected 24000 25600", first_irq, fs_at);
        end
        n_tests++;
        if (vs_rise != 24400 || vs_fall != 24800) begin
            n_fail++; $display("FAIL vsync_window: got %0d..%0d expected 24400..24800", vs_rise, vs_fall);
        end
        bus_rd(2, 4'd0, q);
        n_tests++;
        if (q !== 8'h01) begin
            n_fail++; $display("FAIL frame_count: got %h expected 01", q);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        for (int i = 0; i < 20000 && vpos_c !== 7'd60; i++) tick();
        n_tests++;
        if (vpos_c !== 7'd60 || irq_c !== 1'b1 || bus_c.dout !== 8'h01) begin
            n_fail++; $display("FAIL mid_pre: got v=%0d irq=%b dout=%h expected 60 1 01",
                               vpos_c, irq_c, bus_c.dout);
        end
        rst_c = 1'b1;
        tick();
        n_tests++;
        if ({hpos_c, vpos_c} !== 15'd0 || irq_c !== 1'b0 || bus_c.dout !== 8'h00 ||
            disp_c !== 1'b1 || fs_c !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got h=%0d v=%0d irq=%b dout=%h disp=%b fs=%b expected 0 0 0 00 1 0",
                               hpos_c, vpos_c, irq_c, bus_c.dout, disp_c, fs_c);
        end
        rst_c = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fs_c !== 1'b0 || hpos_c !== 8'(i)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mid_restart: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        set_bus(0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_bus(1, 1'b0, 1'b0, 4'd0, 8'h00);
        set_bus(2, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) tick();
        rst_b = 1'b0; rst_c = 1'b0;
        test_reset();
        test_line();
        test_enable();
        test_random();
        test_irq();
        test_coherent();
        test_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
